// File: rtl/gpu_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_vram_arbiter
//  Purpose  : Grants the single VRAM burst port to one of four GPU clients
//             (display, render, copy, fill) for a whole burst. Display has
//             bounded fixed priority; render/copy/fill share round-robin.
//             A one-cycle turnaround separates consecutive bursts.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_vram_arbiter #(
    parameter int BURST_W  = 5,
    parameter int MAX_DISP = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [3:0]           i_req,
    input  logic [4*BURST_W-1:0] i_burstLen,
    input  logic                 i_memReady,
    output logic [3:0]           o_grant,
    output logic                 o_memValid,
    output logic [1:0]           o_memSel,
    output logic                 o_beatLast,
    output logic                 o_busy
);

    // Display streak counter needs to hold MAX_DISP; never narrower than 2 bits.
    localparam int c_DCNT_W = ($clog2(MAX_DISP + 1) < 2) ? 2 : $clog2(MAX_DISP + 1);
    localparam logic [c_DCNT_W-1:0] c_DISP_MAX = c_DCNT_W'(MAX_DISP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t              r_state_q,    w_state_d;
    logic [3:0]          r_grant_q,    w_grant_d;
    logic [BURST_W-1:0]  r_beat_q,     w_beat_d;
    logic [1:0]          r_rr_ptr_q,   w_rr_ptr_d;
    logic [c_DCNT_W-1:0] r_disp_cnt_q, w_disp_cnt_d;

    logic               w_others;
    logic               w_disp_wins;
    logic               w_rr_found;
    logic [1:0]         w_rr_win;
    logic [2:0]         w_idx;
    logic [1:0]         w_winner;
    logic [BURST_W-1:0] w_len;

    assign w_others    = |i_req[3:1];
    assign w_disp_wins = i_req[0] && ((r_disp_cnt_q < c_DISP_MAX) || !w_others);
    assign w_winner    = w_disp_wins ? 2'd0 : w_rr_win;
    assign w_len       = i_burstLen[w_winner*BURST_W +: BURST_W];

    // Round-robin search over clients 1..3 starting at the pointer, wrapping 3->1.
    always_comb begin
        w_rr_win   = 2'd1;
        w_rr_found = 1'b0;
        w_idx      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            w_idx = {1'b0, r_rr_ptr_q} + 3'(k);
            if (w_idx > 3'd3) begin
                w_idx = w_idx - 3'd3;
            end
            if (!w_rr_found && i_req[w_idx[1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_idx[1:0];
            end
        end
    end

    // Next-state logic: arbitration in IDLE, beat counting in BURST, bubble in TURN.
    always_comb begin
        w_state_d    = r_state_q;
        w_grant_d    = r_grant_q;
        w_beat_d     = r_beat_q;
        w_rr_ptr_d   = r_rr_ptr_q;
        w_disp_cnt_d = r_disp_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (|i_req) begin
                    w_state_d = S_BURST;
                    w_grant_d = 4'b0001 << w_winner;
                    // A zero length field still moves one beat.
                    w_beat_d  = (w_len == '0) ? BURST_W'(1) : w_len;
                    if (w_winner == 2'd0) begin
                        if (!w_others) begin
                            w_disp_cnt_d = '0;
                        end else if (r_disp_cnt_q < c_DISP_MAX) begin
                            w_disp_cnt_d = r_disp_cnt_q + c_DCNT_W'(1);
                        end
                    end else begin
                        w_disp_cnt_d = '0;
                        w_rr_ptr_d   = (w_winner == 2'd3) ? 2'd1 : w_winner + 2'd1;
                    end
                end
            end
            S_BURST: begin
                if (i_memReady) begin
                    w_beat_d = r_beat_q - BURST_W'(1);
                    if (r_beat_q == BURST_W'(1)) begin
                        w_state_d = S_TURN;
                        w_grant_d = 4'b0000;
                    end
                end
            end
            S_TURN: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_grant_d = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous reset; render is first in round-robin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= S_IDLE;
            r_grant_q    <= 4'b0000;
            r_beat_q     <= '0;
            r_rr_ptr_q   <= 2'd1;
            r_disp_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_grant_q    <= w_grant_d;
            r_beat_q     <= w_beat_d;
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_disp_cnt_q <= w_disp_cnt_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        case (r_grant_q)
            4'b0010: o_memSel = 2'd1;
            4'b0100: o_memSel = 2'd2;
            4'b1000: o_memSel = 2'd3;
            default: o_memSel = 2'd0;
        endcase
    end

    assign o_grant    = r_grant_q;
    assign o_memValid = |r_grant_q;
    assign o_beatLast = (r_state_q == S_BURST) && (r_beat_q == BURST_W'(1));
    assign o_busy     = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gpu_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_vram_arbiter
//  Purpose  : Self-checking bench for gpu_vram_arbiter: directed scenarios
//             plus randomized traffic against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpu_vram_arbiter;

    localparam int BURST_W  = 5;
    localparam int MAX_DISP = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           i_req;
    logic [4*BURST_W-1:0] i_burstLen;
    logic                 i_memReady;
    logic [3:0]           o_grant;
    logic                 o_memValid;
    logic [1:0]           o_memSel;
    logic                 o_beatLast;
    logic                 o_busy;

    gpu_vram_arbiter #(.BURST_W(BURST_W), .MAX_DISP(MAX_DISP)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (i_req),
        .i_burstLen (i_burstLen),
        .i_memReady (i_memReady),
        .o_grant    (o_grant),
        .o_memValid (o_memValid),
        .o_memSel   (o_memSel),
        .o_beatLast (o_beatLast),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // Reference model: who owns the port, how many beats remain, and
    // whether the turnaround bubble is pending.
    int m_owner;     // -1 when nobody owns the port
    int m_rem;
    bit m_turn;
    int m_rr;
    int m_dcnt;
    int g_who[$];
    int g_when[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [4*BURST_W-1:0] mk_len(int a, int b, int c, int d);
        logic [BURST_W-1:0] la, lb, lc, ld;
        la = BURST_W'(a); lb = BURST_W'(b); lc = BURST_W'(c); ld = BURST_W'(d);
        return {ld, lc, lb, la};
    endfunction

    function automatic int pick(logic [3:0] req);
        bit others;
        others = (req[3:1] != 3'b000);
        if (req[0] && (m_dcnt < MAX_DISP || !others)) return 0;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = ((m_rr - 1 + k) % 3) + 1;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_owner = -1; m_rem = 0; m_turn = 0; m_rr = 1; m_dcnt = 0;
        end else if (m_owner >= 0) begin
            if (i_memReady) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_owner = -1;
                    m_turn  = 1;
                end
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else if (i_req != 4'b0000) begin
            int w, len;
            w   = pick(i_req);
            len = int'(i_burstLen[w*BURST_W +: BURST_W]);
            m_owner = w;
            m_rem   = (len == 0) ? 1 : len;
            if (w == 0 && i_req[3:1] != 3'b000) m_dcnt = (m_dcnt < MAX_DISP) ? m_dcnt + 1 : MAX_DISP;
            else m_dcnt = 0;
            if (w != 0) m_rr = (w % 3) + 1;
            g_who.push_back(w);
            g_when.push_back(cycle);
        end
    endtask

    task automatic step(input logic [3:0] req, input logic [4*BURST_W-1:0] len,
                        input logic rdy, input logic rs);
        logic [3:0] eg;
        i_req = req; i_burstLen = len; i_memReady = rdy; rst = rs;
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("grant",    32'(o_grant),    32'(eg));
        check("memValid", 32'(o_memValid), 32'(m_owner >= 0));
        check("memSel",   32'(o_memSel),   32'((m_owner >= 0) ? m_owner : 0));
        check("beatLast", 32'(o_beatLast), 32'(m_owner >= 0 && m_rem == 1));
        check("busy",     32'(o_busy),     32'(m_owner >= 0 || m_turn));
        check("onehot",   32'($countones(o_grant) <= 1), 32'(1));
    endtask

    task automatic do_reset();
        step(4'b0000, '0, 1'b1, 1'b1);
        g_who.delete();
        g_when.delete();
    endtask

    initial begin
        int exp_rr[6];
        int exp_dr[8];
        exp_rr = '{1, 2, 3, 1, 2, 3};
        exp_dr = '{0, 0, 0, 1, 0, 0, 0, 1};
        m_owner = -1; m_rem = 0; m_turn = 0; m_rr = 1; m_dcnt = 0;
        i_req = '0; i_burstLen = '0; i_memReady = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, then a single render burst of 4 beats.
        do_reset();
        step(4'b0010, mk_len(0, 4, 0, 0), 1'b1, 1'b0);
        check("render_len4_grant", 32'(o_grant), 32'h2);
        for (int i = 0; i < 6; i++) step(4'b0000, mk_len(0, 4, 0, 0), 1'b1, 1'b0);

        // Render/copy/fill continuously with length 1: order and 3-cycle spacing.
        do_reset();
        for (int i = 0; i < 18; i++) step(4'b1110, mk_len(1, 1, 1, 1), 1'b1, 1'b0);
        check("rr_count", 32'(g_who.size() >= 6), 32'(1));
        for (int i = 0; i < 6 && i < g_who.size(); i++) begin
            check("rr_order", 32'(g_who[i]), 32'(exp_rr[i]));
            if (i > 0) check("rr_spacing", 32'(g_when[i] - g_when[i-1]), 32'(3));
        end

        // Display and render continuously: display streak bounded by MAX_DISP.
        do_reset();
        for (int i = 0; i < 26; i++) step(4'b0011, mk_len(1, 1, 1, 1), 1'b1, 1'b0);
        check("dr_count", 32'(g_who.size() >= 8), 32'(1));
        for (int i = 0; i < 8 && i < g_who.size(); i++) check("dr_order", 32'(g_who[i]), 32'(exp_dr[i]));

        // Zero length field means one beat.
        do_reset();
        step(4'b1000, mk_len(0, 0, 0, 0), 1'b1, 1'b0);
        check("len0_beatLast", 32'(o_beatLast), 32'(1));
        for (int i = 0; i < 3; i++) step(4'b0000, '0, 1'b1, 1'b0);

        // Copy burst of 3 with a stalled memory port.
        do_reset();
        step(4'b0100, mk_len(0, 0, 3, 0), 1'b1, 1'b0);
        step(4'b0100, mk_len(0, 0, 7, 0), 1'b1, 1'b0);
        step(4'b0000, mk_len(0, 0, 7, 0), 1'b0, 1'b0);
        step(4'b0000, mk_len(0, 0, 7, 0), 1'b0, 1'b0);
        check("stall_grant_held", 32'(o_grant), 32'h4);
        for (int i = 0; i < 4; i++) step(4'b0000, '0, 1'b1, 1'b0);

        // Reset during the second beat of a fill burst of 8.
        do_reset();
        step(4'b1000, mk_len(0, 0, 0, 8), 1'b1, 1'b0);
        step(4'b1000, mk_len(0, 0, 0, 8), 1'b1, 1'b0);
        step(4'b1000, mk_len(0, 0, 0, 8), 1'b1, 1'b1);
        check("rst_mid_grant", 32'(o_grant), 32'h0);
        check("rst_mid_busy",  32'(o_busy),  32'h0);
        g_who.delete();
        step(4'b0110, mk_len(0, 2, 2, 0), 1'b1, 1'b0);
        check("post_rst_render_first", 32'(g_who.size() > 0 ? g_who[0] : -1), 32'(1));
        for (int i = 0; i < 6; i++) step(4'b0000, '0, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rq;
            logic [4*BURST_W-1:0] ln;
            rq = 4'($urandom) & 4'($urandom | $urandom);
            ln = mk_len($urandom_range(0, 9), $urandom_range(0, 9),
                        $urandom_range(0, 9), $urandom_range(0, 9));
            step(rq, ln, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
